// File: rtl/ex_mem_stage.sv
// Execute stage (ALU, branch target, destination select) plus the EX/MEM pipeline register.
// Optional operand forwarding from MEM/WB is enabled by defining EX_FORWARDING_EN.
module ex_mem_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             wb_RegWrite,
  input  logic             wb_MemToReg,
  input  logic             mem_MemRead,
  input  logic             mem_MemWrite,
  input  logic             ex_RegDst,
  input  logic             ex_AluSrc,
  input  logic             ex_branch,
  input  logic [1:0]       ex_AluOp,
  input  logic [XLEN-1:0]  pc4,
  input  logic [XLEN-1:0]  read_data1,
  input  logic [XLEN-1:0]  read_data2,
  input  logic [15:0]      immediate,
  input  logic [RADDR-1:0] rs,
  input  logic [RADDR-1:0] rt,
  input  logic [RADDR-1:0] rd,
  input  logic [RADDR-1:0] fwd_mem_rd,
  input  logic [RADDR-1:0] fwd_wb_rd,
  input  logic             fwd_mem_we,
  input  logic             fwd_wb_we,
  input  logic [XLEN-1:0]  fwd_mem_data,
  input  logic [XLEN-1:0]  fwd_wb_data,
  output logic             wb_RegWrite_out,
  output logic             wb_MemToReg_out,
  output logic             mem_MemRead_out,
  output logic             mem_MemWrite_out,
  output logic             branch_out,
  output logic             zero_out,
  output logic [XLEN-1:0]  alu_result_out,
  output logic [XLEN-1:0]  branch_target_out,
  output logic [XLEN-1:0]  store_data_out,
  output logic [RADDR-1:0] dest_out,
  output logic             valid_out
);

  logic [XLEN-1:0]  w_immExt;
  logic [XLEN-1:0]  w_opA;
  logic [XLEN-1:0]  w_regB;
  logic [XLEN-1:0]  w_opB;
  logic [XLEN-1:0]  w_aluResult;
  logic [XLEN-1:0]  w_branchTarget;
  logic [RADDR-1:0] w_dest;
  logic [5:0]       w_funct;

  assign w_immExt = {{(XLEN-16){immediate[15]}}, immediate};
  assign w_funct  = immediate[5:0];

`ifdef EX_FORWARDING_EN
  // Register 0 is hardwired to zero, so it is never a forwarding candidate.
  always_comb begin
    w_opA = read_data1;
    if (fwd_mem_we && (fwd_mem_rd == rs) && (rs != '0))
      w_opA = fwd_mem_data;
    else if (fwd_wb_we && (fwd_wb_rd == rs) && (rs != '0))
      w_opA = fwd_wb_data;
  end

  always_comb begin
    w_regB = read_data2;
    if (fwd_mem_we && (fwd_mem_rd == rt) && (rt != '0))
      w_regB = fwd_mem_data;
    else if (fwd_wb_we && (fwd_wb_rd == rt) && (rt != '0))
      w_regB = fwd_wb_data;
  end
`else
  logic w_unusedFwd;
  assign w_unusedFwd = &{1'b0, fwd_mem_rd, fwd_wb_rd, fwd_mem_we, fwd_wb_we,
                         fwd_mem_data, fwd_wb_data, rs};
  assign w_opA  = read_data1;
  assign w_regB = read_data2;
`endif

  assign w_opB          = ex_AluSrc ? w_immExt : w_regB;
  assign w_branchTarget = pc4 + (w_immExt << 2);
  assign w_dest         = ex_RegDst ? rd : rt;

  always_comb begin
    w_aluResult = '0;
    unique case (ex_AluOp)
      2'b00: w_aluResult = w_opA + w_opB;
      2'b01: w_aluResult = w_opA - w_opB;
      2'b11: w_aluResult = w_opA | w_opB;
      2'b10: begin
        case (w_funct)
          6'b100000: w_aluResult = w_opA + w_opB;
          6'b100010: w_aluResult = w_opA - w_opB;
          6'b100100: w_aluResult = w_opA & w_opB;
          6'b100101: w_aluResult = w_opA | w_opB;
          6'b100111: w_aluResult = ~(w_opA | w_opB);
          6'b101010: w_aluResult = {{(XLEN-1){1'b0}},
                                    ($signed(w_opA) < $signed(w_opB))};
          default:   w_aluResult = '0;
        endcase
      end
      default: w_aluResult = '0;
    endcase
  end

  // Flush only kills the side-effecting controls; data fields are left as-is.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_RegWrite_out   <= 1'b0;
      wb_MemToReg_out   <= 1'b0;
      mem_MemRead_out   <= 1'b0;
      mem_MemWrite_out  <= 1'b0;
      branch_out        <= 1'b0;
      zero_out          <= 1'b0;
      alu_result_out    <= '0;
      branch_target_out <= '0;
      store_data_out    <= '0;
      dest_out          <= '0;
      valid_out         <= 1'b0;
    end else if (flush) begin
      wb_RegWrite_out   <= 1'b0;
      mem_MemRead_out   <= 1'b0;
      mem_MemWrite_out  <= 1'b0;
      branch_out        <= 1'b0;
      valid_out         <= 1'b0;
    end else if (!stall) begin
      wb_RegWrite_out   <= wb_RegWrite;
      wb_MemToReg_out   <= wb_MemToReg;
      mem_MemRead_out   <= mem_MemRead;
      mem_MemWrite_out  <= mem_MemWrite;
      branch_out        <= ex_branch;
      zero_out          <= (w_aluResult == '0);
      alu_result_out    <= w_aluResult;
      branch_target_out <= w_branchTarget;
      store_data_out    <= w_regB;
      dest_out          <= w_dest;
      valid_out         <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed steps followed by randomized traffic
// compared against a behavioural model of the EX/MEM register.
module tb_ex_mem_stage;

  logic        clk;
  logic        reset;
  logic        stall, flush;
  logic        wb_RegWrite, wb_MemToReg, mem_MemRead, mem_MemWrite;
  logic        ex_RegDst, ex_AluSrc, ex_branch;
  logic [1:0]  ex_AluOp;
  logic [31:0] pc4, read_data1, read_data2;
  logic [15:0] immediate;
  logic [4:0]  rs, rt, rd;
  logic [4:0]  fwd_mem_rd, fwd_wb_rd;
  logic        fwd_mem_we, fwd_wb_we;
  logic [31:0] fwd_mem_data, fwd_wb_data;

  logic        wb_RegWrite_out, wb_MemToReg_out, mem_MemRead_out, mem_MemWrite_out;
  logic        branch_out, zero_out, valid_out;
  logic [31:0] alu_result_out, branch_target_out, store_data_out;
  logic [4:0]  dest_out;

  int compared   = 0;
  int mismatched = 0;

  // Expected register contents; mDataKnown is cleared by a bubble, whose data is don't-care.
  logic        mRegWrite, mMemToReg, mMemRead, mMemWrite, mBranch, mZero, mValid;
  logic [31:0] mResult, mTarget, mStore;
  logic [4:0]  mDest;
  logic        mDataKnown;

  ex_mem_stage #(.XLEN(32), .RADDR(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .ex_RegDst(ex_RegDst), .ex_AluSrc(ex_AluSrc), .ex_branch(ex_branch),
    .ex_AluOp(ex_AluOp), .pc4(pc4), .read_data1(read_data1), .read_data2(read_data2),
    .immediate(immediate), .rs(rs), .rt(rt), .rd(rd),
    .fwd_mem_rd(fwd_mem_rd), .fwd_wb_rd(fwd_wb_rd),
    .fwd_mem_we(fwd_mem_we), .fwd_wb_we(fwd_wb_we),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
    .wb_RegWrite_out(wb_RegWrite_out), .wb_MemToReg_out(wb_MemToReg_out),
    .mem_MemRead_out(mem_MemRead_out), .mem_MemWrite_out(mem_MemWrite_out),
    .branch_out(branch_out), .zero_out(zero_out),
    .alu_result_out(alu_result_out), .branch_target_out(branch_target_out),
    .store_data_out(store_data_out), .dest_out(dest_out), .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] signExt(input logic [15:0] v);
    int s;
    s = (v >= 16'h8000) ? int'(v) - 65536 : int'(v);
    return 32'(s);
  endfunction

  function automatic logic [31:0] pickOperand(input logic [4:0] src, input logic [31:0] rf);
`ifdef EX_FORWARDING_EN
    if (src != 0 && fwd_mem_we && fwd_mem_rd == src) return fwd_mem_data;
    if (src != 0 && fwd_wb_we && fwd_wb_rd == src) return fwd_wb_data;
`endif
    return rf;
  endfunction

  function automatic logic [31:0] refAlu(input logic [1:0] op, input logic [5:0] funct,
                                         input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    if (op == 2'd0) return a + b;
    if (op == 2'd1) return a - b;
    if (op == 2'd3) return a | b;
    if (funct == 6'd32) return a + b;
    if (funct == 6'd34) return a - b;
    if (funct == 6'd36) return a & b;
    if (funct == 6'd37) return a | b;
    if (funct == 6'd39) return ~(a | b);
    if (funct == 6'd42) return (sa < sb) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  task automatic modelReset();
    {mRegWrite, mMemToReg, mMemRead, mMemWrite, mBranch, mZero, mValid} = '0;
    mResult = 0; mTarget = 0; mStore = 0; mDest = 0;
    mDataKnown = 1'b1;
  endtask

  task automatic modelEdge();
    logic [31:0] a, rb, b;
    if (flush) begin
      mRegWrite = 0; mMemRead = 0; mMemWrite = 0; mBranch = 0; mValid = 0;
      mDataKnown = 1'b0;
    end else if (!stall) begin
      a  = pickOperand(rs, read_data1);
      rb = pickOperand(rt, read_data2);
      b  = ex_AluSrc ? signExt(immediate) : rb;
      mResult   = refAlu(ex_AluOp, immediate[5:0], a, b);
      mZero     = (mResult == 0);
      mTarget   = pc4 + signExt(immediate) * 4;
      mStore    = rb;
      mDest     = ex_RegDst ? rd : rt;
      mRegWrite = wb_RegWrite; mMemToReg = wb_MemToReg;
      mMemRead  = mem_MemRead; mMemWrite = mem_MemWrite;
      mBranch   = ex_branch;   mValid = 1'b1;
      mDataKnown = 1'b1;
    end
  endtask

  task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    compare({tag, ".wb_RegWrite"}, 32'(wb_RegWrite_out), 32'(mRegWrite));
    compare({tag, ".mem_MemRead"}, 32'(mem_MemRead_out), 32'(mMemRead));
    compare({tag, ".mem_MemWrite"}, 32'(mem_MemWrite_out), 32'(mMemWrite));
    compare({tag, ".branch"}, 32'(branch_out), 32'(mBranch));
    compare({tag, ".valid"}, 32'(valid_out), 32'(mValid));
    if (mDataKnown) begin
      compare({tag, ".wb_MemToReg"}, 32'(wb_MemToReg_out), 32'(mMemToReg));
      compare({tag, ".zero"}, 32'(zero_out), 32'(mZero));
      compare({tag, ".alu_result"}, alu_result_out, mResult);
      compare({tag, ".branch_target"}, branch_target_out, mTarget);
      compare({tag, ".store_data"}, store_data_out, mStore);
      compare({tag, ".dest"}, 32'(dest_out), 32'(mDest));
    end
  endtask

  // Updates the model from the inputs present before the edge, clocks, then checks at edge+1.
  task automatic applyStimulus(input string tag);
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic clearInputs();
    stall = 0; flush = 0;
    wb_RegWrite = 0; wb_MemToReg = 0; mem_MemRead = 0; mem_MemWrite = 0;
    ex_RegDst = 0; ex_AluSrc = 0; ex_branch = 0; ex_AluOp = 0;
    pc4 = 0; read_data1 = 0; read_data2 = 0; immediate = 0;
    rs = 0; rt = 0; rd = 0;
    fwd_mem_rd = 0; fwd_wb_rd = 0; fwd_mem_we = 0; fwd_wb_we = 0;
    fwd_mem_data = 0; fwd_wb_data = 0;
  endtask

  task automatic randomInputs();
    logic [5:0] functs [7];
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h00};
    stall = ($urandom_range(0, 4) == 0);
    flush = ($urandom_range(0, 9) == 0);
    {wb_RegWrite, wb_MemToReg, mem_MemRead, mem_MemWrite} = 4'($urandom);
    {ex_RegDst, ex_AluSrc, ex_branch} = 3'($urandom);
    ex_AluOp   = 2'($urandom);
    pc4        = $urandom & 32'hFFFF_FFFC;
    read_data1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    read_data2 = ($urandom_range(0, 3) == 0) ? read_data1 : $urandom;
    immediate  = 16'($urandom);
    if (ex_AluOp == 2'b10) immediate[5:0] = functs[$urandom_range(0, 6)];
    rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom);
    fwd_mem_rd = 5'($urandom_range(0, 3)); fwd_wb_rd = 5'($urandom_range(0, 3));
    fwd_mem_we = 1'($urandom); fwd_wb_we = 1'($urandom);
    fwd_mem_data = $urandom; fwd_wb_data = $urandom;
  endtask

  initial begin
    clearInputs();
    modelReset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");

    @(negedge clk);
    reset = 1'b1;
    applyStimulus("firstLoad");

    ex_AluOp = 2'b10; immediate = 16'h0022; read_data1 = 5; read_data2 = 7;
    ex_RegDst = 1; rd = 9; rt = 4; wb_RegWrite = 1;
    applyStimulus("subFunct");
    compare("subFunct.const", alu_result_out, 32'hFFFF_FFFE);

    clearInputs();
    ex_AluOp = 2'b01; read_data1 = 32'h1234; read_data2 = 32'h1234;
    ex_branch = 1; pc4 = 32'h100; immediate = 16'hFFFF;
    applyStimulus("beq");
    compare("beq.target", branch_target_out, 32'hFC);

    clearInputs();
    wb_RegWrite = 1; mem_MemWrite = 1; ex_AluOp = 2'b10; immediate = 16'h002A;
    read_data1 = 32'hFFFF_FFF0; read_data2 = 3; rt = 6;
    applyStimulus("slt");
    stall = 1; read_data1 = 99; immediate = 16'h0020; rt = 11;
    applyStimulus("stall1");
    read_data2 = 1234;
    applyStimulus("stall2");
    flush = 1;
    applyStimulus("stallFlush");
    stall = 0; flush = 0;
    applyStimulus("afterFlush");

    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput("asyncReset");
    @(negedge clk);
    reset = 1'b1;

    clearInputs();
    rs = 3; fwd_mem_rd = 3; fwd_mem_we = 1; fwd_mem_data = 40;
    fwd_wb_rd = 3; fwd_wb_we = 1; fwd_wb_data = 50;
    ex_AluSrc = 1; immediate = 16'd2;
    applyStimulus("fwdMem");
`ifdef EX_FORWARDING_EN
    compare("fwdMem.const", alu_result_out, 32'd42);
`else
    compare("fwdMem.const", alu_result_out, 32'd2);
`endif
    rs = 0; fwd_mem_rd = 0; fwd_wb_rd = 0; read_data1 = 7;
    applyStimulus("fwdZero");
    compare("fwdZero.const", alu_result_out, 32'd9);

    for (int i = 0; i < 400; i++) begin
      randomInputs();
      applyStimulus("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register.
- Consumes the ID/EX register outputs: control bits, pc4, both operands, the 16-bit immediate, rs, rt and rd.
- Computes the ALU result, zero flag, branch target and destination register, then registers them with the WB/MEM control bits for the MEM stage.
- Supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
- XLEN, 32, datapath width of operands, result, pc4 and branch target.
- RADDR, 5, register-specifier width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 clears the register.
- stall  in  1  hold all registered outputs.
- flush  in  1  load a bubble.
- wb_RegWrite, wb_MemToReg, mem_MemRead, mem_MemWrite, ex_RegDst, ex_AluSrc, ex_branch  in  1 each  ID/EX control.
- ex_AluOp  in  2  ALU operation class.
- pc4, read_data1, read_data2  in  XLEN  ID/EX data.
- immediate  in  16  raw immediate; bits [5:0] are funct.
- rs, rt, rd  in  RADDR  register specifiers.
- fwd_mem_rd, fwd_wb_rd  in  RADDR  destinations in MEM and WB.
- fwd_mem_we, fwd_wb_we  in  1  write enables in MEM and WB.
- fwd_mem_data, fwd_wb_data  in  XLEN  results in MEM and WB.
- wb_RegWrite_out, wb_MemToReg_out, mem_MemRead_out, mem_MemWrite_out, branch_out  out  1  registered control.
- zero_out  out  1  registered ALU zero flag.
- alu_result_out, branch_target_out, store_data_out  out  XLEN  registered data.
- dest_out  out  RADDR  registered destination register.
- valid_out  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- Reset (reset=0, asynchronous): every output is 0. branch_out=0 guarantees no spurious PC redirect before the first instruction reaches MEM.
- Operand A = read_data1.
- store_data = read_data2.
- Operand B = sign-extended immediate if ex_AluSrc=1, else read_data2.
- ALU decode by ex_AluOp:
  - 00: add.
  - 01: sub.
  - 11: or.
  - 10: decode funct: 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt (signed; result 1 or 0). Any other funct gives result 0.
- Arithmetic: wraps modulo 2^XLEN; no overflow trap. zero = (result == 0).
- branch_target = pc4 + (sign-extended immediate << 2), modulo 2^XLEN.
- dest = rd if ex_RegDst=1, else rt.
- Latency: exactly 1 cycle from inputs to registered outputs.
- Rising edge, priority when reset=1:
  1. flush=1 loads a bubble: wb_RegWrite_out, mem_MemRead_out, mem_MemWrite_out, branch_out and valid_out go to 0; data outputs are don't-care and may be loaded. Flush wins over stall.
  2. Else stall=1: all outputs hold.
  3. Else all outputs load, and valid_out=1.
- Reset asserted mid-operation clears state immediately; an in-flight instruction is lost.
- After deassertion, the first edge loads normally.
- Operands with stall=1 are recomputed each cycle; only the register holds.

Optional Feature:
- Macro: EX_FORWARDING_EN.
- Defined: A and B are taken from a forwarding mux before the operand selection above. Forwarding to B applies only to the register operand; store_data is forwarded as well.
  - Source rs (for A) / rt (for B) matches fwd_mem_rd with fwd_mem_we=1 and the register is not 0: use fwd_mem_data.
  - Else it matches fwd_wb_rd with fwd_wb_we=1 and the register is not 0: use fwd_wb_data.
  - Else use the register-file value.
  - MEM has priority over WB.
- Undefined: the fwd_* ports stay present but are ignored, and the operands come straight from read_data1/read_data2.

Test Plan:
- Hold reset=0, then release and clock once with zero inputs: branch_out=0, valid_out=0 during reset, every output 0, valid_out=1 after the edge.
- AluOp=10, funct=100010, rd1=5, rd2=7, RegDst=1, rd=9: alu_result_out=0xFFFFFFFE, zero_out=0, dest_out=9 one cycle later.
- AluOp=01, rd1=rd2=0x1234, branch=1, pc4=0x100, imm=0xFFFF: zero_out=1, branch_out=1, branch_target_out=0xFC.
- Sequence of valid instructions:
  - stall=1 for 2 cycles: outputs unchanged.
  - stall=1 and flush=1 together: wb_RegWrite_out=0, mem_MemWrite_out=0, valid_out=0.
- Assert reset=0 asynchronously between edges with wb_RegWrite_out=1: it drops to 0 without a clock edge.
- With EX_FORWARDING_EN defined:
  - rs=3, fwd_mem_rd=3, fwd_mem_we=1, fwd_mem_data=40, fwd_wb_rd=3, fwd_wb_we=1, fwd_wb_data=50, rd1=0, AluOp=00, AluSrc=1, imm=2: result 42.
  - rs=0 with matching rd=0 forwarding entries: not forwarded.
  - Same stimulus without the macro: result 2.
